// File: rtl/msg_prep_pkg.sv
// Shared constants and state type for the padded-message reader.
package msg_prep_pkg;

    localparam int unsigned MSG_W         = 1024;
    localparam int unsigned HDR_W         = 640;
    localparam int unsigned BLK_W         = 512;
    localparam int unsigned WORD_W        = 32;
    localparam int unsigned WORDS_PER_BLK = 16;
    localparam int unsigned MSG_LEN_BITS  = 640;
    localparam int unsigned SEP_BIT       = 383;
    localparam int unsigned LEN_W         = 64;
    localparam int unsigned ERR_CNT_W     = 8;
    localparam int unsigned CNT_W         = 5;
    localparam int unsigned IDX_W         = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_e;

endpackage

// File: rtl/msg_pad_checker.sv
// Combinational SHA-256 padding check for a 640-bit header: separator bit,
// zero fill and a 64-bit length field equal to 640.
module msg_pad_checker
    import msg_prep_pkg::*;
(
    input  logic [SEP_BIT:0] pad_field,
    output logic             pad_ok
);

    always_comb begin
        pad_ok = pad_field[SEP_BIT]
              && (pad_field[SEP_BIT-1:LEN_W] == '0)
              && (pad_field[LEN_W-1:0] == LEN_W'(MSG_LEN_BITS));
    end

endmodule

// File: rtl/message_block_reader.sv
// Accepts one 1024-bit padded message and streams it as 32 big-endian words.
// Define MSG_PAD_CHECK_EN to reject messages with malformed padding.
module message_block_reader
    import msg_prep_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [MSG_W-1:0]     in_msg,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_W-1:0]    out_word,
    output logic [IDX_W-1:0]     out_word_idx,
    output logic                 out_blk_idx,
    output logic                 out_blk_last,
    output logic                 out_msg_last,
    output logic                 pad_err,
    output logic [ERR_CNT_W-1:0] pad_err_cnt,
    output logic                 busy
);

    state_e           state_q, state_d;
    logic [MSG_W-1:0] msg_q, msg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ready_q, valid_q, blk_last_q, msg_last_q;
    logic             valid_d, blk_last_d, msg_last_d;
    logic             pad_ok_c;

`ifdef MSG_PAD_CHECK_EN
    logic                 err_q, err_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    msg_pad_checker u_pad_checker (
        .pad_field (in_msg[SEP_BIT:0]),
        .pad_ok    (pad_ok_c)
    );
`else
    assign pad_ok_c = 1'b1;
`endif

    // Next-state logic; msg_q shifts left so the current word is always on top.
    always_comb begin
        state_d = state_q;
        msg_d   = msg_q;
        cnt_d   = cnt_q;
`ifdef MSG_PAD_CHECK_EN
        err_d     = 1'b0;
        err_cnt_d = err_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    cnt_d = '0;
                    if (pad_ok_c) begin
                        msg_d   = in_msg;
                        state_d = STREAM;
                    end
`ifdef MSG_PAD_CHECK_EN
                    else begin
                        err_d = 1'b1;
                        if (err_cnt_q != '1)
                            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
                    end
`endif
                end
            end
            STREAM: begin
                if (out_ready) begin
                    msg_d = {msg_q[MSG_W-WORD_W-1:0], WORD_W'(0)};
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == '1)
                        state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        valid_d    = (state_d == STREAM);
        blk_last_d = valid_d && (cnt_d[IDX_W-1:0] == '1);
        msg_last_d = valid_d && (cnt_d == '1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            msg_q      <= '0;
            cnt_q      <= '0;
            ready_q    <= 1'b1;
            valid_q    <= 1'b0;
            blk_last_q <= 1'b0;
            msg_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            msg_q      <= msg_d;
            cnt_q      <= cnt_d;
            ready_q    <= (state_d == IDLE);
            valid_q    <= valid_d;
            blk_last_q <= blk_last_d;
            msg_last_q <= msg_last_d;
        end
    end

`ifdef MSG_PAD_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign pad_err     = err_q;
    assign pad_err_cnt = err_cnt_q;
`else
    assign pad_err     = 1'b0;
    assign pad_err_cnt = '0;
`endif

    assign in_ready     = ready_q;
    assign out_valid    = valid_q;
    assign busy         = valid_q;
    assign out_word     = msg_q[MSG_W-1 -: WORD_W];
    assign out_word_idx = cnt_q[IDX_W-1:0];
    assign out_blk_idx  = cnt_q[CNT_W-1];
    assign out_blk_last = blk_last_q;
    assign out_msg_last = msg_last_q;

endmodule

// File: tb/tb_message_block_reader.sv
// Scoreboard bench for message_block_reader: stimulus pushes expected words,
// a negedge monitor pops and compares on every transfer.
module tb_message_block_reader;
    import msg_prep_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [MSG_W-1:0]     in_msg = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [WORD_W-1:0]    out_word;
    logic [IDX_W-1:0]     out_word_idx;
    logic                 out_blk_idx;
    logic                 out_blk_last;
    logic                 out_msg_last;
    logic                 pad_err;
    logic [ERR_CNT_W-1:0] pad_err_cnt;
    logic                 busy;

    message_block_reader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_msg       (in_msg),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_word     (out_word),
        .out_word_idx (out_word_idx),
        .out_blk_idx  (out_blk_idx),
        .out_blk_last (out_blk_last),
        .out_msg_last (out_msg_last),
        .pad_err      (pad_err),
        .pad_err_cnt  (pad_err_cnt),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] w;
        logic [3:0]  wi;
        logic        bi;
        logic        bl;
        logic        ml;
    } exp_t;

    exp_t        q[$];
    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Expected word k of a message with header words base+k and given length.
    function automatic logic [31:0] exp_word(input logic [31:0] base, input logic [31:0] len, input int k);
        if (k < 20)       return base + 32'(k);
        else if (k == 20) return 32'h8000_0000;
        else if (k == 31) return len;
        else              return 32'h0;
    endfunction

    function automatic logic [MSG_W-1:0] build_msg(input logic [31:0] base, input logic [31:0] len);
        logic [MSG_W-1:0] m;
        m = '0;
        for (int k = 0; k < 32; k++)
            m[MSG_W-1-32*k -: 32] = exp_word(base, len, k);
        return m;
    endfunction

    task automatic push_msg(input logic [31:0] base, input logic [31:0] len, input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.w  = exp_word(base, len, k);
            e.wi = 4'(k % 16);
            e.bi = (k >= 16);
            e.bl = ((k % 16) == 15);
            e.ml = (k == 31);
            q.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [MSG_W-1:0] m);
        in_msg   = m;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name, input bit toggle);
        int i;
        i = 0;
        while (q.size() != 0 && i < 600) begin
            if (toggle) out_ready = ((i % 4) == 0) || ((i % 4) == 3);
            tick();
            i++;
        end
        out_ready = 1'b1;
        chk(name, 64'(q.size()), 64'd0);
    endtask

    // Monitor: scoreboard compare on transfers, hold check while stalled.
    exp_t        mon_e;
    logic [63:0] snap;
    bit          stalled = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            if (stalled)
                chk("stall_hold", {25'd0, out_word, out_word_idx, out_blk_idx, out_blk_last, out_msg_last}, snap);
            if (out_valid) begin
                chk("stream_in_ready", 64'(in_ready), 64'd0);
                chk("stream_busy", 64'(busy), 64'd1);
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    n_total++;
                    $display("FAIL extra_word: got word 0x%0h idx %0d expected no transfer", out_word, out_word_idx);
                end else begin
                    mon_e = q.pop_front();
                    chk("word",     64'(out_word),     64'(mon_e.w));
                    chk("word_idx", 64'(out_word_idx), 64'(mon_e.wi));
                    chk("blk_idx",  64'(out_blk_idx),  64'(mon_e.bi));
                    chk("blk_last", 64'(out_blk_last), 64'(mon_e.bl));
                    chk("msg_last", 64'(out_msg_last), 64'(mon_e.ml));
                end
            end
            stalled = out_valid && !out_ready;
            snap    = {25'd0, out_word, out_word_idx, out_blk_idx, out_blk_last, out_msg_last};
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int i;
        // Reset
        repeat (3) tick();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_word", 64'(out_word), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err_cnt", 64'(pad_err_cnt), 64'd0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        chk("post_rst_out_valid", 64'(out_valid), 64'd0);

        // Full-rate stream
        out_ready = 1'b1;
        push_msg(32'h0, 32'd640, 32);
        send(build_msg(32'h0, 32'd640));
        chk("latency_valid", 64'(out_valid), 64'd1);
        chk("latency_idx", 64'(out_word_idx), 64'd0);
        drain("t1_drain", 1'b0);
        tick();
        chk("t1_idle_ready", 64'(in_ready), 64'd1);
        chk("t1_idle_valid", 64'(out_valid), 64'd0);

        // Backpressure 1,0,0,1
        push_msg(32'h0, 32'd640, 32);
        send(build_msg(32'h0, 32'd640));
        drain("t2_drain", 1'b1);
        tick();
        chk("t2_idle_ready", 64'(in_ready), 64'd1);

        // Bad length field
`ifdef MSG_PAD_CHECK_EN
        send(build_msg(32'h0, 32'h200));
        chk("bad_pad_err", 64'(pad_err), 64'd1);
        chk("bad_no_valid", 64'(out_valid), 64'd0);
        chk("bad_in_ready", 64'(in_ready), 64'd1);
        tick();
        chk("bad_pulse_end", 64'(pad_err), 64'd0);
        chk("bad_cnt1", 64'(pad_err_cnt), 64'd1);
        in_valid = 1'b1;
        repeat (300) tick();
        in_valid = 1'b0;
        tick();
        chk("bad_cnt_sat", 64'(pad_err_cnt), 64'd255);
        chk("bad_sat_no_valid", 64'(out_valid), 64'd0);
`else
        push_msg(32'h40, 32'h200, 32);
        send(build_msg(32'h40, 32'h200));
        chk("nochk_pad_err", 64'(pad_err), 64'd0);
        drain("nochk_drain", 1'b0);
        chk("nochk_err_cnt", 64'(pad_err_cnt), 64'd0);
`endif

        // Reset while word 10 is presented
        out_ready = 1'b1;
        push_msg(32'h300, 32'd640, 10);
        send(build_msg(32'h300, 32'd640));
        i = 0;
        while (!(out_valid && out_word_idx == 4'd10) && i < 40) begin
            tick();
            i++;
        end
        chk("t4_reach_w10", 64'(out_word), 64'h30a);
        rst_n = 1'b0;
        #1;
        chk("t4_rst_valid", 64'(out_valid), 64'd0);
        chk("t4_rst_word", 64'(out_word), 64'd0);
        chk("t4_rst_idx", {59'd0, out_blk_idx, out_word_idx}, 64'd0);
        chk("t4_rst_busy", 64'(busy), 64'd0);
        chk("t4_popped", 64'(q.size()), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        push_msg(32'h400, 32'd640, 32);
        send(build_msg(32'h400, 32'd640));
        chk("t4_restart_word0", 64'(out_word), 64'h400);
        drain("t4_drain", 1'b0);

        // Back-to-back with in_valid held
        push_msg(32'h500, 32'd640, 32);
        push_msg(32'h600, 32'd640, 32);
        in_msg   = build_msg(32'h500, 32'd640);
        in_valid = 1'b1;
        tick();
        in_msg = build_msg(32'h600, 32'd640);
        i = 0;
        while (!(out_valid && out_msg_last) && i < 60) begin
            tick();
            i++;
        end
        chk("t5_reach_last", 64'(out_word), 64'h280);
        tick();
        chk("t5_gap_ready", 64'(in_ready), 64'd1);
        chk("t5_gap_valid", 64'(out_valid), 64'd0);
        tick();
        in_valid = 1'b0;
        chk("t5_b_valid", 64'(out_valid), 64'd1);
        chk("t5_b_word0", 64'(out_word), 64'h600);
        drain("t5_drain", 1'b0);

        repeat (3) tick();
        chk("final_idle", 64'(out_valid), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/message_block_reader.md
Name: message_block_reader

Overview:
- Consumer-side counterpart of the header padding stage.
- Accepts one 1024-bit padded SHA-256 message (640-bit block header + padding + 64-bit length) over a valid/ready handshake.
- Optionally validates the padding, then streams the message as 32 big-endian 32-bit words (two 512-bit blocks of 16 words) to the SHA-256 compression/schedule core.
- Sits between the padding stage and the hash core, and decouples the wide parallel bus from the word-serial core.

Parameters:
- MSG_W, 1024, padded message width; fixed at 2×512.
- WORD_W, 32, output word width.
- ERR_CNT_W, 8, width of the saturating padding-error counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  padded message present on in_msg.
- in_ready  out  1  block can accept a message.
- in_msg  in  1024  padded message; bit 1023 is the first bit of the header.
- out_valid  out  1  out_word is valid.
- out_ready  in  1  core accepts out_word.
- out_word  out  32  current message word.
- out_word_idx  out  4  word index within the current block, 0..15.
- out_blk_idx  out  1  block number: 0 = first 512 bits, 1 = second.
- out_blk_last  out  1  high on word 15 of each block.
- out_msg_last  out  1  high on word 15 of block 1 (word 31 overall).
- pad_err  out  1  one-cycle pulse: rejected message.
- pad_err_cnt  out  ERR_CNT_W  saturating count of rejected messages.
- busy  out  1  high while in STREAM.

Behaviour:
- Reset values (asynchronous, rst_n low):
  - State = IDLE; in_ready=1 once rst_n deasserts.
  - out_valid=0, out_word=0, out_word_idx=0, out_blk_idx=0, out_blk_last=0, out_msg_last=0.
  - pad_err=0, pad_err_cnt=0, busy=0.
  - Message register cleared.
- FSM, two states:
  - IDLE: in_ready=1. On in_valid&in_ready, capture in_msg into msg_q and clear the 5-bit word counter cnt. Go to STREAM, or stay in IDLE if a padding error is detected (see Optional Feature).
  - STREAM: in_ready=0, out_valid=1, busy=1. On out_valid&out_ready, increment cnt. The transfer with cnt=31 returns the FSM to IDLE.
- Word output:
  - out_word = msg_q[1023-32*cnt -: 32], driven from registered state only.
  - out_word_idx = cnt[3:0]; out_blk_idx = cnt[4].
  - out_blk_last = (cnt[3:0]==15); out_msg_last = (cnt==31).
- Latency: a message accepted in cycle N produces out_valid high with word 0 in cycle N+1.
- Backpressure: while out_ready=0, out_word and all index outputs hold stable. No word is skipped or duplicated.
- Throughput: 32 cycles per message at full out_ready, plus one IDLE cycle between messages (no accept on the cycle of the last word transfer).
- in_valid during STREAM is ignored, because in_ready=0. The upstream source holds its data.
- Reset mid-STREAM aborts the message. No partial resume; the next accepted message starts at word 0.

Optional Feature:
- Macro: MSG_PAD_CHECK_EN.
- Defined:
  - On accept, check in_msg[383]==1, in_msg[382:64]==0 and in_msg[63:0]==64'd640.
  - On failure: no STREAM; pad_err pulses high in cycle N+1; pad_err_cnt increments, saturating at 2^ERR_CNT_W-1; FSM stays in IDLE with in_ready=1.
- Undefined: no check; every accepted message is streamed; pad_err and pad_err_cnt are tied to 0.

Decomposition:
- Package msg_prep_pkg holds:
  - Constants MSG_W=1024, HDR_W=640, BLK_W=512, WORD_W=32, WORDS_PER_BLK=16, MSG_LEN_BITS=640, SEP_BIT=383.
  - State enum {IDLE, STREAM}.
- One sub-module, msg_pad_checker: purely combinational, in_msg → pad_ok. Instantiated only under MSG_PAD_CHECK_EN.

Test Plan:
- Reset held low, then released → in_ready=1, out_valid=0, pad_err_cnt=0.
- Valid message with header words 0x00000000..0x00000013 (word k = k), out_ready=1 → out_valid in the cycle after accept; 32 words out.
  - Word 19 = 0x00000013.
  - Word 20 = 0x80000000, with out_blk_idx=1 and out_word_idx=4.
  - Words 21..30 = 0.
  - Word 31 = 0x00000280 with out_msg_last=1.
  - out_blk_last high on words 15 and 31.
- Same message, out_ready toggling 1,0,0,1 → out_word stable while stalled; exactly 32 transfers; in_ready=0 until after word 31.
- With MSG_PAD_CHECK_EN, length field 0x00000200 → pad_err pulses 1 cycle; pad_err_cnt=1; no out_valid. Then 300 bad messages → pad_err_cnt saturates at 255.
- rst_n pulsed low at word 10 of a stream → outputs return to reset values immediately. Next message streams from word 0 correctly.
- in_valid held high continuously with two distinct messages → second accepted exactly one cycle after the first's word 31 transfer.
